// File: rtl/mem_dma_pkg.sv
// Shared types and default widths for the memory-copy DMA master.
package mem_dma_pkg;

  localparam int unsigned DMA_ADDR_W = 16;
  localparam int unsigned DMA_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage : mem_dma_pkg

// File: rtl/mem_copy_dma.sv
// Block-copy master for a single-port-write / async-read word memory.
// Each word costs two cycles: READ captures the word, WRITE commits it.
// Build option MEM_COPY_DMA_BACKWARD_EN: overlapping copies with dst above
// src run from the top of the block downward (memmove semantics).
module mem_copy_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = DMA_ADDR_W,
  parameter int unsigned DATA_W = DMA_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_input,
  output logic              busy,
  output logic              done
);

  dma_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] src_step_c, dst_step_c;
  logic [ADDR_W-1:0] src_start_c, dst_start_c;

`ifdef MEM_COPY_DMA_BACKWARD_EN
  logic              bwd_q, bwd_d;
  logic              overlap_c;

  // Detect a destination that lands inside the not-yet-read source window.
  always_comb begin
    overlap_c   = (dst_addr > src_addr) && (ADDR_W'(dst_addr - src_addr) < length);
    src_start_c = src_addr;
    dst_start_c = dst_addr;
    if (overlap_c) begin
      src_start_c = ADDR_W'(src_addr + length - ADDR_W'(1));
      dst_start_c = ADDR_W'(dst_addr + length - ADDR_W'(1));
    end
  end

  // Per-word pointer advance, downward for a backward copy.
  always_comb begin
    if (bwd_q) begin
      src_step_c = ADDR_W'(src_q - ADDR_W'(1));
      dst_step_c = ADDR_W'(dst_q - ADDR_W'(1));
    end else begin
      src_step_c = ADDR_W'(src_q + ADDR_W'(1));
      dst_step_c = ADDR_W'(dst_q + ADDR_W'(1));
    end
  end
`else
  // Start pointers come straight from the request.
  always_comb begin
    src_start_c = src_addr;
    dst_start_c = dst_addr;
  end

  // Per-word pointer advance; wraps modulo 2^ADDR_W.
  always_comb begin
    src_step_c = ADDR_W'(src_q + ADDR_W'(1));
    dst_step_c = ADDR_W'(dst_q + ADDR_W'(1));
  end
`endif

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
`ifdef MEM_COPY_DMA_BACKWARD_EN
    bwd_d     = bwd_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src_start_c;
          dst_d = dst_start_c;
          rem_d = length;
`ifdef MEM_COPY_DMA_BACKWARD_EN
          bwd_d = overlap_c;
`endif
          state_d = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        data_d  = mem_read_data;
        state_d = WRITE;
      end
      WRITE: begin
        src_d   = src_step_c;
        dst_d   = dst_step_c;
        rem_d   = ADDR_W'(rem_q - ADDR_W'(1));
        state_d = (rem_q == ADDR_W'(1)) ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Read address is only updated on entry to READ and held otherwise.
    if (state_d == READ) begin
      rd_addr_d = src_d;
    end

    wr_d   = (state_d == WRITE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any copy in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      rd_addr_q <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef MEM_COPY_DMA_BACKWARD_EN
  // Copy direction chosen at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bwd_q <= 1'b0;
    end else begin
      bwd_q <= bwd_d;
    end
  end
`endif

  assign mem_read_address  = rd_addr_q;
  assign mem_write         = wr_q;
  assign mem_write_address = dst_q;
  assign mem_write_input   = data_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule : mem_copy_dma

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma with a word-level copy model.
module tb_mem_copy_dma;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic [15:0] mem_read_data;
  logic [15:0] mem_read_address;
  logic        mem_write;
  logic [15:0] mem_write_address;
  logic [15:0] mem_write_input;
  logic        busy;
  logic        done;

  mem_copy_dma dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .length            (length),
    .mem_read_data     (mem_read_data),
    .mem_read_address  (mem_read_address),
    .mem_write         (mem_write),
    .mem_write_address (mem_write_address),
    .mem_write_input   (mem_write_input),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory the DUT talks to, and the model's view of the same memory.
  logic [15:0] mem     [65536];
  logic [15:0] exp_mem [65536];

  assign mem_read_data = mem[mem_read_address];

  always @(posedge clk) begin
    if (mem_write) mem[mem_write_address] <= mem_write_input;
  end

  typedef struct packed {
    logic        busy;
    logic        rd;
    logic        wr;
    logic        done;
    logic [15:0] raddr;
    logic [15:0] waddr;
    logic [15:0] wdata;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Per-cycle comparison against the expected cycle schedule.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr", 32'(mem_write), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_raddr", 32'(mem_read_address), 32'd0);
      chk("rst_waddr", 32'(mem_write_address), 32'd0);
      chk("rst_wdata", 32'(mem_write_input), 32'd0);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("mem_write", 32'(mem_write), 32'(e.wr));
      chk("done", 32'(done), 32'(e.done));
      if (e.rd) chk("rd_addr", 32'(mem_read_address), 32'(e.raddr));
      if (e.wr) begin
        chk("wr_addr", 32'(mem_write_address), 32'(e.waddr));
        chk("wr_data", 32'(mem_write_input), 32'(e.wdata));
        exp_mem[e.waddr] = e.wdata;
      end
    end else begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_wr", 32'(mem_write), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
  end

  // Activity counters for whole-transfer checks.
  always @(negedge clk) begin
    if (mem_write) wr_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  // Expected cycles of one copy: a READ/WRITE pair per word, then DONE.
  task automatic schedule(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    logic [15:0] ov [logic [15:0]];
    logic        bwd;
    exp_t        e;
    logic [15:0] sa, da, v;
    int          k;
    bwd = 1'b0;
`ifdef MEM_COPY_DMA_BACKWARD_EN
    bwd = (d > s) && (16'(d - s) < n);
`endif
    for (int i = 0; i < int'(n); i++) begin
      k  = bwd ? (int'(n) - 1 - i) : i;
      sa = 16'(s + 16'(k));
      da = 16'(d + 16'(k));
      v  = ov.exists(sa) ? ov[sa] : exp_mem[sa];
      e = '0; e.busy = 1'b1; e.rd = 1'b1; e.raddr = sa;
      q.push_back(e);
      e = '0; e.busy = 1'b1; e.wr = 1'b1; e.waddr = da; e.wdata = v;
      q.push_back(e);
      ov[da] = v;
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    q.push_back(e);
  endtask

  // Present one start request; returns just after the accepting edge.
  task automatic copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    exp_t e;
    @(posedge clk); #1;
    wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
    start = 1'b1; src_addr = s; dst_addr = d; length = n;
    e = '0;
    q.push_back(e);
    schedule(s, d, n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (q.size() > 0 && cnt < 300) begin
      @(posedge clk);
      cnt++;
    end
    if (q.size() > 0) chk("timeout", 32'd1, 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    mem[a] = v;
    exp_mem[a] = v;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'h0;
      exp_mem[i] = 16'h0;
    end
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic four-word forward copy.
    preload(16'h0010, 16'h00A1); preload(16'h0011, 16'h00A2);
    preload(16'h0012, 16'h00A3); preload(16'h0013, 16'h00A4);
    copy(16'h0010, 16'h0100, 16'd4);
    wait_idle();
    chk("t1_m100", 32'(mem[16'h0100]), 32'h00A1);
    chk("t1_m101", 32'(mem[16'h0101]), 32'h00A2);
    chk("t1_m102", 32'(mem[16'h0102]), 32'h00A3);
    chk("t1_m103", 32'(mem[16'h0103]), 32'h00A4);
    chk("t1_model103", 32'(exp_mem[16'h0103]), 32'h00A4);
    chk("t1_writes", 32'(wr_cnt), 32'd4);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("t1_dones", 32'(done_cnt), 32'd1);

    // Zero-length request.
    preload(16'h0200, 16'h5A5A);
    copy(16'h0000, 16'h0200, 16'd0);
    wait_idle();
    chk("t2_writes", 32'(wr_cnt), 32'd0);
    chk("t2_dones", 32'(done_cnt), 32'd1);
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd1);
    chk("t2_m200", 32'(mem[16'h0200]), 32'h5A5A);

    // Source address wraps through 0xFFFF.
    preload(16'hFFFE, 16'd1); preload(16'hFFFF, 16'd2); preload(16'h0000, 16'd3);
    copy(16'hFFFE, 16'h0020, 16'd3);
    wait_idle();
    chk("t3_m20", 32'(mem[16'h0020]), 32'd1);
    chk("t3_m21", 32'(mem[16'h0021]), 32'd2);
    chk("t3_m22", 32'(mem[16'h0022]), 32'd3);
    chk("t3_model22", 32'(exp_mem[16'h0022]), 32'd3);

    // Start pulsed while busy is ignored.
    copy(16'h0010, 16'h0300, 16'd4);
    @(posedge clk); #1;
    start = 1'b1; src_addr = 16'h0010; dst_addr = 16'h0400; length = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    chk("t4_dones", 32'(done_cnt), 32'd1);
    chk("t4_writes", 32'(wr_cnt), 32'd4);
    chk("t4_m303", 32'(mem[16'h0303]), 32'h00A4);
    chk("t4_m400", 32'(mem[16'h0400]), 32'h0000);

    // Reset during the WRITE of word 2 of 4.
    copy(16'h0010, 16'h0500, 16'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_pre_rst_wr", 32'(mem_write), 32'd1);
    rst = 1'b1;
    q.delete();
    #1;
    chk("t5_rst_wr", 32'(mem_write), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle();
    chk("t5_m500", 32'(mem[16'h0500]), 32'h00A1);
    chk("t5_m501", 32'(mem[16'h0501]), 32'h0000);
    chk("t5_writes", 32'(wr_cnt), 32'd1);
    chk("t5_dones", 32'(done_cnt), 32'd0);

    // Overlapping copy, dst one above src.
    preload(16'h0040, 16'd7); preload(16'h0041, 16'd8); preload(16'h0042, 16'd9);
    copy(16'h0040, 16'h0041, 16'd3);
    wait_idle();
`ifdef MEM_COPY_DMA_BACKWARD_EN
    chk("t6_m41", 32'(mem[16'h0041]), 32'd7);
    chk("t6_m42", 32'(mem[16'h0042]), 32'd8);
    chk("t6_m43", 32'(mem[16'h0043]), 32'd9);
    chk("t6_model43", 32'(exp_mem[16'h0043]), 32'd9);
`else
    chk("t6_m41", 32'(mem[16'h0041]), 32'd7);
    chk("t6_m42", 32'(mem[16'h0042]), 32'd7);
    chk("t6_m43", 32'(mem[16'h0043]), 32'd7);
    chk("t6_model43", 32'(exp_mem[16'h0043]), 32'd7);
`endif
    chk("t6_dones", 32'(done_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_copy_dma
